// File: rtl/i2s_rx_deserializer.sv
// I2S slave receiver: oversamples SCLK/LRCLK/SDATA in the MCLK domain and emits L/R pairs.
// Latency: outputs update 4 MCLK after the SCLK rise that carries a slot's LSB; no backpressure (pulsed outputs).
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  MCLK,
  input  logic                  RST,
  input  logic                  SCLK,
  input  logic                  LRCLK,
  input  logic                  SDATA,
  output logic [DATA_WIDTH-1:0] L_DATA,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  VALID,
  output logic                  FRAME_ERR,
  output logic                  LOCKED
);

  localparam logic [6:0] DW7 = 7'(DATA_WIDTH);
  localparam logic [6:0] SW7 = 7'(SLOT_WIDTH);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_e;

  state_e state_q, state_d;

  // Bit order in each stage: {SCLK, LRCLK, SDATA}
  logic [2:0] sync1_q, sync2_q, dly_q;
  logic       strobe_q;

  logic                  ws_q, ws_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  left_ok_q, left_ok_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  locked_q, locked_d;
  logic [DATA_WIDTH-1:0] l_data_q, l_data_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic       bit_s, ws_s, boundary, slot_ok;
  logic [6:0] cnt_inc;

  assign bit_s    = dly_q[0];
  assign ws_s     = dly_q[1];
  assign boundary = strobe_q && (ws_s != ws_q);
  assign cnt_inc  = (cnt_q == 7'd127) ? 7'd127 : cnt_q + 7'd1;
  // The boundary strobe's bit still belongs to the ending slot, so its length is cnt_inc
  assign slot_ok  = (cnt_inc == SW7);

  always_comb begin
    ws_d  = ws_q;
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (strobe_q) begin
      ws_d  = ws_s;
      cnt_d = boundary ? 7'd0 : cnt_inc;
      if (cnt_q < DW7) sh_d = (sh_q << 1) | DATA_WIDTH'(bit_s);
    end
  end

  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) state_q <= HUNT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        HUNT:    if (!ws_s) state_d = LEFT;
        LEFT:    state_d = RIGHT;
        RIGHT:   state_d = LEFT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    hold_d    = hold_q;
    left_ok_d = left_ok_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    locked_d  = locked_q;
    l_data_d  = l_data_q;
    r_data_d  = r_data_q;
    if (boundary) begin
      case (state_q)
        LEFT: begin
          if (slot_ok) begin
            hold_d    = sh_d;
            left_ok_d = 1'b1;
          end else begin
            ferr_d    = 1'b1;
            left_ok_d = 1'b0;
            locked_d  = 1'b0;
          end
        end
        RIGHT: begin
          if (slot_ok && left_ok_q) begin
            l_data_d = hold_q;
            r_data_d = sh_d;
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else if (!slot_ok) begin
            ferr_d   = 1'b1;
            locked_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      dly_q     <= '0;
      strobe_q  <= 1'b0;
      ws_q      <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= '0;
      hold_q    <= '0;
      left_ok_q <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      locked_q  <= 1'b0;
      l_data_q  <= '0;
      r_data_q  <= '0;
    end else begin
      sync1_q   <= {SCLK, LRCLK, SDATA};
      sync2_q   <= sync1_q;
      dly_q     <= sync2_q;
      strobe_q  <= sync2_q[2] & ~dly_q[2];
      ws_q      <= ws_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      hold_q    <= hold_d;
      left_ok_q <= left_ok_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      locked_q  <= locked_d;
      l_data_q  <= l_data_d;
      r_data_q  <= r_data_d;
    end
  end

  assign L_DATA    = l_data_q;
  assign R_DATA    = r_data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign LOCKED    = locked_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: bit-level I2S stimulus, slot-level queue model, per-cycle compare.
module tb_i2s_rx_deserializer;
  localparam int DW = 24;
  localparam int SW = 32;

  logic          MCLK = 1'b0;
  logic          RST = 1'b1;
  logic          SCLK = 1'b0;
  logic          LRCLK = 1'b0;
  logic          SDATA = 1'b0;
  logic [DW-1:0] L_DATA, R_DATA;
  logic          VALID, FRAME_ERR, LOCKED;

  i2s_rx_deserializer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
    .MCLK(MCLK), .RST(RST), .SCLK(SCLK), .LRCLK(LRCLK), .SDATA(SDATA),
    .L_DATA(L_DATA), .R_DATA(R_DATA), .VALID(VALID), .FRAME_ERR(FRAME_ERR), .LOCKED(LOCKED)
  );

  always #5 MCLK = ~MCLK;

  int cyc = 0;
  always @(posedge MCLK) cyc++;

  typedef struct {
    int          c;
    bit          is_valid;
    logic [23:0] l;
    logic [23:0] r;
  } evt_t;

  evt_t evq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   valid_cnt = 0, ferr_cnt = 0, last_v = 0, prev_v = 0;

  // Slot-level reference: bits of the current slot in a queue, evaluated at each LRCLK change
  bit          hunt = 1'b1;
  bit          prev_ws = 1'b0;
  bit          left_ok = 1'b0;
  logic [23:0] hold = '0;
  bit          bitq[$];
  bit          pend = 1'b0;

  logic [DW-1:0] exp_l = '0, exp_r = '0;
  bit            exp_lock = 1'b0;

  function automatic logic [23:0] first_bits();
    logic [23:0] v = '0;
    for (int i = 0; i < DW; i++) v = {v[22:0], (i < bitq.size()) ? bitq[i] : 1'b0};
    return v;
  endfunction

  // A boundary seen at SCLK rise in cycle c shows at the outputs in cycle c+4
  task automatic model_rising(input bit ws, input bit d);
    int          len;
    logic [23:0] val;
    evt_t        e;
    bitq.push_back(d);
    if (ws != prev_ws) begin
      len = bitq.size();
      val = first_bits();
      e.c = cyc + 4; e.is_valid = 1'b0; e.l = '0; e.r = '0;
      if (hunt) begin
        if (ws == 1'b0) hunt = 1'b0;
      end else if (prev_ws == 1'b0) begin
        if (len == SW) begin hold = val; left_ok = 1'b1; end
        else begin left_ok = 1'b0; evq.push_back(e); end
      end else begin
        if (len == SW && left_ok) begin
          e.is_valid = 1'b1; e.l = hold; e.r = val; evq.push_back(e);
        end else if (len != SW) begin
          evq.push_back(e);
        end
      end
      bitq.delete();
      prev_ws = ws;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge MCLK) begin : cmp
    evt_t e;
    bit   ev, ef;
    #1;
    if (!RST) begin
      evq.delete(); exp_l = '0; exp_r = '0; exp_lock = 1'b0;
    end
    ev = 1'b0; ef = 1'b0;
    while (evq.size() > 0 && evq[0].c < cyc) void'(evq.pop_front());
    if (evq.size() > 0 && evq[0].c == cyc) begin
      e = evq.pop_front();
      if (e.is_valid) begin ev = 1'b1; exp_l = e.l; exp_r = e.r; exp_lock = 1'b1; end
      else begin ef = 1'b1; exp_lock = 1'b0; end
    end
    vectors++;
    if ({VALID, FRAME_ERR, LOCKED, L_DATA, R_DATA} !== {ev, ef, exp_lock, exp_l, exp_r}) begin
      miscompares++;
      $display("FAIL cycle %0d: got valid=%b ferr=%b locked=%b L=%h R=%h, expected valid=%b ferr=%b locked=%b L=%h R=%h",
               cyc, VALID, FRAME_ERR, LOCKED, L_DATA, R_DATA, ev, ef, exp_lock, exp_l, exp_r);
    end
    if (VALID === 1'b1) begin valid_cnt++; prev_v = last_v; last_v = cyc; end
    if (FRAME_ERR === 1'b1) ferr_cnt++;
  end

  // One SCLK period (4 MCLK); entered and left on a falling MCLK edge
  task automatic drive_period(input bit ws, input bit d);
    SCLK = 1'b0; LRCLK = ws; SDATA = d;
    @(negedge MCLK); @(negedge MCLK);
    SCLK = 1'b1;
    model_rising(ws, d);
    @(negedge MCLK); @(negedge MCLK);
  endtask

  // Slot bits are emitted one SCLK late (I2S one-bit delay); bits past 64 read as 1
  task automatic send_range(input bit ch, input int k0, input int k1, input logic [63:0] w);
    for (int k = k0; k < k1; k++) begin
      drive_period(ch, pend);
      pend = (k < 64) ? w[63-k] : 1'b1;
    end
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int nl, input int nr);
    send_range(1'b0, 0, nl, l);
    send_range(1'b1, 0, nr, r);
  endtask

  task automatic flush();
    send_range(1'b0, 0, 6, 64'h0);
    repeat (8) @(negedge MCLK);
  endtask

  task automatic do_reset(input bit chk);
    RST = 1'b0;
    hunt = 1'b1; prev_ws = 1'b0; left_ok = 1'b0; bitq.delete();
    @(negedge MCLK);
    if (chk) begin
      #1;
      check("rst_l_data", 64'(L_DATA), 64'h0);
      check("rst_r_data", 64'(R_DATA), 64'h0);
      check("rst_valid", 64'(VALID), 64'h0);
      check("rst_ferr", 64'(FRAME_ERR), 64'h0);
      check("rst_locked", 64'(LOCKED), 64'h0);
    end
    @(negedge MCLK); @(negedge MCLK);
    RST = 1'b1;
  endtask

  function automatic logic [63:0] rw();
    return {$urandom(), $urandom()};
  endfunction

  function automatic int rlen();
    int r = $urandom_range(0, 11);
    case (r)
      0: return 31;
      1: return 30;
      2: return 33;
      3: return 34;
      4: return 140;
      default: return 32;
    endcase
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w2l, w2r, wl, wr;
    int v0, f0;
    @(negedge MCLK);
    do_reset(1'b1);

    // Nominal stream starting at a left slot
    v0 = valid_cnt; f0 = ferr_cnt;
    repeat (4) send_frame({24'h123456, 40'hFF_FFFF_FFFF}, {24'hABCDEF, 40'hFF_FFFF_FFFF}, 32, 32);
    flush();
    check("nom_l_data", 64'(L_DATA), 64'h123456);
    check("nom_r_data", 64'(R_DATA), 64'hABCDEF);
    check("nom_locked", 64'(LOCKED), 64'h1);
    check("nom_valid_count", 64'(valid_cnt - v0), 64'd3);
    check("nom_ferr_count", 64'(ferr_cnt - f0), 64'd0);
    check("nom_valid_period", 64'(last_v - prev_v), 64'd256);

    // Start mid-right-slot, full-scale values
    do_reset(1'b0);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_range(1'b1, 0, 10, rw());
    repeat (3) send_frame({24'h800000, 40'h0}, {24'h7FFFFF, 40'h0}, 32, 32);
    flush();
    check("fs_l_data", 64'(L_DATA), 64'h800000);
    check("fs_r_data", 64'(R_DATA), 64'h7FFFFF);
    check("mid_valid_count", 64'(valid_cnt - v0), 64'd3);
    check("mid_ferr_count", 64'(ferr_cnt - f0), 64'd0);

    // Short left slot in the third frame
    do_reset(1'b0);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(rw(), rw(), 32, 32);
    w2l = rw(); w2r = rw();
    send_frame(w2l, w2r, 32, 32);
    send_frame(rw(), rw(), 31, 32);
    check("short_locked_drop", 64'(LOCKED), 64'h0);
    check("short_hold_l", 64'(L_DATA), 64'(w2l[63:40]));
    check("short_hold_r", 64'(R_DATA), 64'(w2r[63:40]));
    send_frame({24'h13579B, 40'h0}, {24'h2468AC, 40'h0}, 32, 32);
    send_frame({24'hFEDCBA, 40'h0}, {24'h012345, 40'h0}, 32, 32);
    flush();
    check("short_valid_count", 64'(valid_cnt - v0), 64'd3);
    check("short_ferr_count", 64'(ferr_cnt - f0), 64'd1);
    check("short_l_data", 64'(L_DATA), 64'hFEDCBA);
    check("short_r_data", 64'(R_DATA), 64'h012345);
    check("short_relock", 64'(LOCKED), 64'h1);

    // Long right slot in the third frame
    do_reset(1'b0);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(rw(), rw(), 32, 32);
    send_frame(rw(), rw(), 32, 32);
    send_frame(rw(), rw(), 32, 33);
    send_frame(rw(), rw(), 32, 32);
    send_frame(rw(), rw(), 32, 32);
    flush();
    check("long_valid_count", 64'(valid_cnt - v0), 64'd3);
    check("long_ferr_count", 64'(ferr_cnt - f0), 64'd1);

    // Reset in the middle of a right slot
    do_reset(1'b0);
    send_frame(rw(), rw(), 32, 32);
    send_frame(rw(), rw(), 32, 32);
    wr = rw();
    send_range(1'b0, 0, 32, rw());
    send_range(1'b1, 0, 12, wr);
    do_reset(1'b1);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_range(1'b1, 12, 32, wr);
    send_frame(rw(), rw(), 32, 32);
    wl = rw(); wr = rw();
    send_frame(wl, wr, 32, 32);
    flush();
    check("rstmid_valid_count", 64'(valid_cnt - v0), 64'd2);
    check("rstmid_ferr_count", 64'(ferr_cnt - f0), 64'd0);
    check("rstmid_l_data", 64'(L_DATA), 64'(wl[63:40]));
    check("rstmid_r_data", 64'(R_DATA), 64'(wr[63:40]));

    // Random data with occasional bad or missing-toggle slots
    for (int i = 0; i < 14; i++) send_frame(rw(), rw(), rlen(), rlen());
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
